// File: rtl/mdu_hilo_pkg.sv
// Shared definitions for the multiply/divide unit: opcodes, FSM states,
// the packed HI/LO pair and the behavioural arithmetic used at start.
package mdu_hilo_pkg;

    typedef enum logic [3:0] {
        MDU_NONE  = 4'd0,
        MDU_MULT  = 4'd1,
        MDU_MULTU = 4'd2,
        MDU_DIV   = 4'd3,
        MDU_DIVU  = 4'd4,
        MDU_MFHI  = 4'd5,
        MDU_MFLO  = 4'd6,
        MDU_MTHI  = 4'd7,
        MDU_MTLO  = 4'd8
    } mdu_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_BUSY = 1'b1
    } mdu_state_e;

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } hilo_t;

    function automatic logic is_mul(input logic [3:0] op);
        return (op == MDU_MULT) || (op == MDU_MULTU);
    endfunction

    function automatic logic is_div(input logic [3:0] op);
        return (op == MDU_DIV) || (op == MDU_DIVU);
    endfunction

    function automatic hilo_t mdu_compute(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] prod;
        hilo_t       r;
        prod = '0;
        r    = '0;
        case (op)
            // Low 64 bits of a 64x64 product of sign-extended operands equal the signed product.
            MDU_MULT: begin
                prod = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                r    = prod;
            end
            MDU_MULTU: begin
                prod = {32'd0, a} * {32'd0, b};
                r    = prod;
            end
            MDU_DIV: begin
                if (b == 32'd0) begin
                    r.hi = a;
                    r.lo = 32'hFFFF_FFFF;
                end else if ((a == 32'h8000_0000) && (b == 32'hFFFF_FFFF)) begin
                    r.hi = 32'd0;
                    r.lo = 32'h8000_0000;
                end else begin
                    r.lo = $signed(a) / $signed(b);
                    r.hi = $signed(a) % $signed(b);
                end
            end
            MDU_DIVU: begin
                if (b == 32'd0) begin
                    r.hi = a;
                    r.lo = 32'hFFFF_FFFF;
                end else begin
                    r.lo = a / b;
                    r.hi = a % b;
                end
            end
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mdu_hilo.sv
// Multiply/divide unit with HI/LO registers; results commit MUL_LAT/DIV_LAT cycles after start.
// No queueing: ops presented while busy are dropped, so the hazard unit must stall on start|busy.
// Optional MDU_CANCEL_EN adds a cancel input that aborts an in-flight op and blocks new writes.
module mdu_hilo
    import mdu_hilo_pkg::*;
#(
    parameter int MUL_LAT = 5,
    parameter int DIV_LAT = 10
) (
    input  logic        clk,
    input  logic        reset,
`ifdef MDU_CANCEL_EN
    input  logic        cancel,
`endif
    input  logic        en,
    input  logic [3:0]  mdu_op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    output logic        busy,
    output logic        start,
    output logic [31:0] mduResult
);

    localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
    localparam int CNT_W   = (MAX_LAT < 2) ? 1 : $clog2(MAX_LAT + 1);

    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;
    hilo_t              pend_q, pend_d;
    logic               cancel_i;
    logic               op_muldiv;

`ifdef MDU_CANCEL_EN
    assign cancel_i = cancel;
`else
    assign cancel_i = 1'b0;
`endif

    assign op_muldiv = is_mul(mdu_op) || is_div(mdu_op);
    assign busy      = (state_q == MDU_BUSY);
    assign start     = en && op_muldiv && (state_q == MDU_IDLE) && !cancel_i;

    // Reads ignore en so the result mux can be driven during a stalled EX.
    always_comb begin
        mduResult = 32'd0;
        if (mdu_op == MDU_MFHI) begin
            mduResult = hi_q;
        end else if (mdu_op == MDU_MFLO) begin
            mduResult = lo_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        pend_d  = pend_q;
        case (state_q)
            MDU_IDLE: begin
                if (start) begin
                    pend_d  = mdu_compute(mdu_op, srcA, srcB);
                    cnt_d   = is_mul(mdu_op) ? CNT_W'(MUL_LAT) : CNT_W'(DIV_LAT);
                    state_d = MDU_BUSY;
                end else if (en && !cancel_i) begin
                    if (mdu_op == MDU_MTHI) begin
                        hi_d = srcA;
                    end else if (mdu_op == MDU_MTLO) begin
                        lo_d = srcA;
                    end
                end
            end
            MDU_BUSY: begin
                if (cancel_i) begin
                    cnt_d   = '0;
                    state_d = MDU_IDLE;
                end else if (cnt_q == CNT_W'(1)) begin
                    hi_d    = pend_q.hi;
                    lo_d    = pend_q.lo;
                    cnt_d   = '0;
                    state_d = MDU_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = MDU_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= MDU_IDLE;
            cnt_q   <= '0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_mdu_hilo.sv
// Self-checking bench for mdu_hilo: vector table plus hand-written busy/reset/cancel sequences.
module tb_mdu_hilo;
    import mdu_hilo_pkg::*;

    localparam int MUL_LAT = 5;
    localparam int DIV_LAT = 10;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  mdu_op;
    logic [31:0] srcA;
    logic [31:0] srcB;
    logic        busy;
    logic        start;
    logic [31:0] mduResult;
`ifdef MDU_CANCEL_EN
    logic        cancel;
`endif

    typedef struct {
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
    } res_t;

    vec_t vecs[10];
    res_t sb[$];
    int   checks = 0;
    int   errors = 0;

    mdu_hilo #(.MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
        .clk       (clk),
        .reset     (reset),
`ifdef MDU_CANCEL_EN
        .cancel    (cancel),
`endif
        .en        (en),
        .mdu_op    (mdu_op),
        .srcA      (srcA),
        .srcB      (srcB),
        .busy      (busy),
        .start     (start),
        .mduResult (mduResult)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_hilo(input string tag, input logic [31:0] hi, input logic [31:0] lo);
        en = 1'b0;
        mdu_op = MDU_MFHI;
        #1 chk({tag, " MFHI"}, mduResult, hi);
        mdu_op = MDU_MFLO;
        #1 chk({tag, " MFLO"}, mduResult, lo);
        mdu_op = MDU_NONE;
        #1;
    endtask

    // Drives one mul/div for a single cycle; returns positioned in the first busy cycle.
    task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] hi, input logic [31:0] lo, input bit push);
        res_t r;
        en = 1'b1;
        mdu_op = op;
        srcA = a;
        srcB = b;
        #1 chk("start on issue", {31'd0, start}, 32'd1);
        if (push) begin
            r.hi = hi;
            r.lo = lo;
            sb.push_back(r);
        end
        tick();
        en = 1'b0;
        mdu_op = MDU_NONE;
    endtask

    task automatic drain(input string tag, input int already, input int lat);
        int   n;
        res_t r;
        n = already;
        while (busy === 1'b1 && n < 300) begin
            srcA = $urandom;
            srcB = $urandom;
            n++;
            tick();
        end
        chk({tag, " busy cycles"}, 32'(n), 32'(lat));
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s scoreboard: got empty queue, expected a pending result", tag);
        end else begin
            r = sb.pop_front();
            read_hilo(tag, r.hi, r.lo);
        end
    endtask

    initial begin
        vecs[0] = '{MDU_MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA, MUL_LAT};
        vecs[1] = '{MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, MUL_LAT};
        vecs[2] = '{MDU_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, DIV_LAT};
        vecs[3] = '{MDU_DIVU,  32'd7,         32'd0,        32'd7,         32'hFFFF_FFFF, DIV_LAT};
        vecs[4] = '{MDU_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'd0,        32'h8000_0000, DIV_LAT};
        vecs[5] = '{MDU_DIV,   32'd7,         32'hFFFF_FFFE, 32'd1,        32'hFFFF_FFFD, DIV_LAT};
        vecs[6] = '{MDU_DIVU,  32'hFFFF_FFFF, 32'd10,       32'd5,         32'h1999_9999, DIV_LAT};
        vecs[7] = '{MDU_MULT,  32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'd0,        MUL_LAT};
        vecs[8] = '{MDU_MULTU, 32'h1234_5678, 32'd16,       32'd1,         32'h2345_6780, MUL_LAT};
        vecs[9] = '{MDU_DIV,   32'hFFFF_FFFB, 32'd0,        32'hFFFF_FFFB, 32'hFFFF_FFFF, DIV_LAT};

        reset = 1'b1;
        en = 1'b0;
        mdu_op = MDU_NONE;
        srcA = 32'd0;
        srcB = 32'd0;
`ifdef MDU_CANCEL_EN
        cancel = 1'b0;
`endif
        tick();
        tick();
        chk("reset busy", {31'd0, busy}, 32'd0);
        mdu_op = MDU_MULT;
        #1 chk("reset start with en=0", {31'd0, start}, 32'd0);
        read_hilo("reset", 32'd0, 32'd0);
        reset = 1'b0;
        tick();

        // Back-to-back MTHI/MTLO, then a write with en low that must be dropped.
        en = 1'b1;
        mdu_op = MDU_MTHI;
        srcA = 32'h1234;
        #1 chk("mthi start", {31'd0, start}, 32'd0);
        tick();
        chk("mthi busy", {31'd0, busy}, 32'd0);
        en = 1'b1;
        mdu_op = MDU_MTLO;
        srcA = 32'h5678;
        tick();
        chk("mtlo busy", {31'd0, busy}, 32'd0);
        en = 1'b0;
        mdu_op = MDU_MTHI;
        srcA = 32'hDEAD_BEEF;
        tick();
        read_hilo("mthi/mtlo", 32'h1234, 32'h5678);
        chk("none result", mduResult, 32'd0);

        // MULT in flight: a second MULT and an MTHI are ignored, reads see old HI/LO.
        issue(MDU_MULT, 32'd3, 32'd7, 32'd0, 32'd21, 1'b1);
        en = 1'b1;
        mdu_op = MDU_MULT;
        srcA = 32'd100;
        srcB = 32'd100;
        #1 chk("start while busy", {31'd0, start}, 32'd0);
        chk("busy cycle 1", {31'd0, busy}, 32'd1);
        tick();
        en = 1'b1;
        mdu_op = MDU_MTHI;
        srcA = 32'hBEEF;
        tick();
        read_hilo("busy read", 32'h1234, 32'h5678);
        tick();
        drain("ignored ops", 3, MUL_LAT);

        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, 1'b1);
            drain($sformatf("vec%0d", i), 0, vecs[i].lat);
        end

        // Reset in busy cycle 3 of a DIV aborts it and clears HI/LO at once.
        issue(MDU_DIV, 32'd100, 32'd7, 32'd0, 32'd0, 1'b0);
        tick();
        tick();
        reset = 1'b1;
        #1 chk("mid-op reset busy", {31'd0, busy}, 32'd0);
        read_hilo("mid-op reset", 32'd0, 32'd0);
        tick();
        reset = 1'b0;
        tick();
        chk("post-reset busy", {31'd0, busy}, 32'd0);
        issue(MDU_MULT, 32'd4, 32'd5, 32'd0, 32'd20, 1'b1);
        drain("post-reset mult", 0, MUL_LAT);

`ifdef MDU_CANCEL_EN
        en = 1'b1;
        mdu_op = MDU_MTHI;
        srcA = 32'd1;
        tick();
        mdu_op = MDU_MTLO;
        srcA = 32'd2;
        tick();
        issue(MDU_MULT, 32'd6, 32'd7, 32'd0, 32'd0, 1'b0);
        tick();
        cancel = 1'b1;
        tick();
        cancel = 1'b0;
        chk("cancel busy", {31'd0, busy}, 32'd0);
        read_hilo("cancel", 32'd1, 32'd2);
        cancel = 1'b1;
        en = 1'b1;
        mdu_op = MDU_MULT;
        srcA = 32'd9;
        srcB = 32'd9;
        #1 chk("cancel suppresses start", {31'd0, start}, 32'd0);
        tick();
        chk("cancel no busy", {31'd0, busy}, 32'd0);
        mdu_op = MDU_MTHI;
        srcA = 32'd99;
        tick();
        cancel = 1'b0;
        read_hilo("cancel mthi", 32'd1, 32'd2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_hilo.md
Name: mdu_hilo

Overview:
- Multiply/divide unit with HI/LO registers; sits in the EX stage beside the ALU and consumes the same forwarded srcA/srcB operands.
- Executes MULT/MULTU/DIV/DIVU over a fixed multi-cycle latency and exposes busy to the hazard unit.
- Services MFHI/MFLO (combinational read into the EX result mux) and MTHI/MTLO (register write).

Parameters:
MUL_LAT, 5, busy cycles for MULT/MULTU (>=1)
DIV_LAT, 10, busy cycles for DIV/DIVU (>=1)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high; clears all state
en  input  1  EX instruction valid and not stalled/flushed; mdu_op honoured only when 1
mdu_op  input  4  operation code (MDU_* constants)
srcA  input  32  rs operand / dividend / multiplicand
srcB  input  32  rt operand / divisor / multiplier
busy  output  1  operation in flight
start  output  1  combinational: en & mdu_op is MULT/MULTU/DIV/DIVU & !busy
mduResult  output  32  HI for MDU_MFHI, LO for MDU_MFLO, else 0 (combinational)

Behaviour:
- Reset: hi=0, lo=0, counter=0, state=IDLE, busy=0; pending product/quotient registers=0. Reset asserted mid-operation aborts it; HI/LO end at 0.
- States: IDLE, BUSY. busy = (state==BUSY).
- IDLE, start at edge k:
  - compute the full result from srcA/srcB at that edge into pend_hi/pend_lo.
  - load counter = MUL_LAT or DIV_LAT; go to BUSY.
- BUSY: decrement counter each edge. On the edge where counter==1, write hi<=pend_hi, lo<=pend_lo and return to IDLE.
  - busy is high in cycles k+1 .. k+LAT.
  - MFHI/MFLO in cycle k+LAT+1 sees the new values.
- MULT: signed 32x32 to 64; hi=[63:32], lo=[31:0]. MULTU: same, unsigned.
- DIV: lo=signed quotient (truncate toward zero), hi=remainder (sign of dividend). DIVU: unsigned.
- Divisor zero: lo=32'hFFFF_FFFF, hi=srcA; normal latency.
- DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
- MTHI/MTLO with en and !busy: hi/lo <= srcA at edge; other register unchanged; busy stays 0.
- Any mul/div/MTHI/MTLO presented while busy: ignored, no state change. The hazard unit must stall; this block does not queue.
- MFHI/MFLO while busy: returns current, pre-operation HI/LO. The hazard unit stalls these on start|busy.
- en=0 or MDU_NONE: no state change; mduResult=0 unless mdu_op is MFHI/MFLO, which read regardless of en.
- Operands are latched only at start; srcA/srcB may change freely while busy.

Optional Feature:
- Macro MDU_CANCEL_EN adds input port cancel (1 bit), driven by the exception/interrupt logic.
  - With the macro: cancel=1 while BUSY returns to IDLE at the next edge with HI/LO unchanged.
  - cancel=1 together with a would-be start suppresses the start.
  - cancel has priority over MTHI/MTLO in the same cycle (write suppressed).
- Without the macro: no port; every started operation always commits.

Decomposition:
- def.v gains MDU_NONE=0, MDU_MULT=1, MDU_MULTU=2, MDU_DIV=3, MDU_DIVU=4, MDU_MFHI=5, MDU_MFLO=6, MDU_MTHI=7, MDU_MTLO=8, plus state encodings MDU_IDLE/MDU_BUSY.
- No sub-module. Arithmetic uses behavioural operators computed at start; timing is modelled by the counter.

Test Plan:
- MULT srcA=0xFFFFFFFE(-2), srcB=3 -> busy cycles 1..5, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; MFLO at cycle 6 = 0xFFFFFFFA.
- MULTU 0xFFFFFFFF*0xFFFFFFFF -> hi=0xFFFFFFFE, lo=0x00000001 after 5 busy cycles.
- DIV -7/2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF after 10 busy cycles; DIVU 7/0 -> lo=0xFFFFFFFF, hi=7.
- MTHI 0x1234 then MTLO 0x5678 back-to-back -> MFHI=0x1234, MFLO=0x5678; busy never asserts; MULT issued while busy ignored (HI/LO match first op only).
- Assert reset in busy cycle 3 of DIV -> busy=0, hi=lo=0 immediately; next MULT 4*5 gives lo=20.
- With MDU_CANCEL_EN: MULT with HI/LO preloaded 1/2, cancel at busy cycle 2 -> busy=0 next cycle, hi=1, lo=2.
